// File: rtl/register_file_p.sv
// register_file_p: parametrised two-read / one-write register file.
// Each entry has a pending (scoreboard) bit, and a sequencer can clear the
// array one entry per cycle.
//   clk, rst           : clock and asynchronous active-high reset
//   ra1/ra2 -> rd1/rd2 : combinational read data
//   rb1/rb2            : combinational pending bit of ra1/ra2
//   we, wa, wd         : write port; a write clears the entry's pending bit
//   mark, ma           : set the pending bit of entry ma
//   clr, clr_busy      : start a full-array clear / clear in progress
module register_file_p #(
  parameter int unsigned W       = 32,
  parameter int unsigned AW      = 3,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  output logic          rb1,
  output logic          rb2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          mark,
  input  logic [AW-1:0] ma,
  input  logic          clr,
  output logic          clr_busy
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     rf_q [DEPTH];
  logic [W-1:0]     rf_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic busy;
  logic zero_wa, zero_ma, zero_ra1, zero_ra2;
  logic byp1, byp2;

  assign busy     = (state_q == S_CLEAR);
  assign clr_busy = busy;

  // Accesses to entry 0 are suppressed when it is the hard-wired zero register
  assign zero_wa  = (ZERO_R0 != 0) && (wa  == '0);
  assign zero_ma  = (ZERO_R0 != 0) && (ma  == '0);
  assign zero_ra1 = (ZERO_R0 != 0) && (ra1 == '0);
  assign zero_ra2 = (ZERO_R0 != 0) && (ra2 == '0);

  // Forward same-cycle write data; disabled while the clear runs
  assign byp1 = (BYPASS != 0) && we && !busy && (wa == ra1) && !zero_ra1;
  assign byp2 = (BYPASS != 0) && we && !busy && (wa == ra2) && !zero_ra2;

  // Read ports
  always_comb begin
    rd1 = rf_q[ra1];
    rb1 = pend_q[ra1];
    rd2 = rf_q[ra2];
    rb2 = pend_q[ra2];
    if (byp1) begin
      rd1 = wd;
      rb1 = 1'b0;
    end
    if (byp2) begin
      rd2 = wd;
      rb2 = 1'b0;
    end
    if (zero_ra1) begin
      rd1 = '0;
      rb1 = 1'b0;
    end
    if (zero_ra2) begin
      rd2 = '0;
      rb2 = 1'b0;
    end
  end

  // Next-state: normal write/mark in IDLE, one entry zeroed per cycle in CLEAR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    pend_d  = pend_q;
    if (state_q == S_IDLE) begin
      if (we && !zero_wa) begin
        rf_d[wa]   = wd;
        pend_d[wa] = 1'b0;
      end
      // Applied after the write so a same-address mark wins
      if (mark && !zero_ma) begin
        pend_d[ma] = 1'b1;
      end
      if (clr) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      rf_d[cnt_q]   = '0;
      pend_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + AW'(1);  // wraps to 0 on the final entry
      if (cnt_q == LAST) begin
        state_d = S_IDLE;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_register_file_p.sv
// tb_register_file_p: self-checking bench for register_file_p.
// Two instances share all inputs: u_dut (no zero register, bypass on) and
// u_dut_z (zero register, bypass off). A behavioural model predicts both.
module tb_register_file_p;

  localparam int unsigned W     = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa, ma;
  logic [W-1:0]  wd;
  logic          we, mark, clr;

  logic [W-1:0]  rd1_o [2];
  logic [W-1:0]  rd2_o [2];
  logic          rb1_o [2];
  logic          rb2_o [2];
  logic          busy_o [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_p #(.W(W), .AW(AW), .ZERO_R0(0), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_o[0]), .rd2(rd2_o[0]),
    .rb1(rb1_o[0]), .rb2(rb2_o[0]),
    .we(we), .wa(wa), .wd(wd), .mark(mark), .ma(ma),
    .clr(clr), .clr_busy(busy_o[0])
  );

  register_file_p #(.W(W), .AW(AW), .ZERO_R0(1), .BYPASS(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_o[1]), .rd2(rd2_o[1]),
    .rb1(rb1_o[1]), .rb2(rb2_o[1]),
    .we(we), .wa(wa), .wd(wd), .mark(mark), .ma(ma),
    .clr(clr), .clr_busy(busy_o[1])
  );

  // Reference model: plain arrays plus the index of the next entry to clear
  logic [W-1:0] m_rf   [2][DEPTH];
  bit           m_pend [2][DEPTH];
  int           m_clr_idx;  // -1 when no clear is running

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return m_clr_idx >= 0;
  endfunction

  // Instance 1 has the zero register; instance 0 has bypass
  function automatic void m_read(input int k, input logic [AW-1:0] a,
                                 output logic [W-1:0] d, output logic b);
    if (k == 1 && a == 0) begin
      d = '0; b = 1'b0;
    end else if (k == 0 && we && !m_busy() && wa == a) begin
      d = wd; b = 1'b0;
    end else begin
      d = m_rf[k][a]; b = m_pend[k][a];
    end
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_rf[k][i]   = '0;
        m_pend[k][i] = 1'b0;
      end
    m_clr_idx = -1;
  endtask

  task automatic m_edge();
    if (m_busy()) begin
      for (int k = 0; k < 2; k++) begin
        m_rf[k][m_clr_idx]   = '0;
        m_pend[k][m_clr_idx] = 1'b0;
      end
      m_clr_idx++;
      if (m_clr_idx == int'(DEPTH)) m_clr_idx = -1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we && !(k == 1 && wa == 0)) begin
          m_rf[k][wa]   = wd;
          m_pend[k][wa] = 1'b0;
        end
        if (mark && !(k == 1 && ma == 0)) m_pend[k][ma] = 1'b1;
      end
      if (clr) m_clr_idx = 0;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] d;
    logic         b;
    for (int k = 0; k < 2; k++) begin
      m_read(k, ra1, d, b);
      chk($sformatf("rd1[%0d]", k), rd1_o[k], d);
      chk($sformatf("rb1[%0d]", k), W'(rb1_o[k]), W'(b));
      m_read(k, ra2, d, b);
      chk($sformatf("rd2[%0d]", k), rd2_o[k], d);
      chk($sformatf("rb2[%0d]", k), W'(rb2_o[k]), W'(b));
      chk($sformatf("busy[%0d]", k), W'(busy_o[k]), W'(m_busy()));
    end
  endtask

  // Check mid-cycle, then advance the model across the rising edge
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_idle();
    we = 1'b0; wa = '0; wd = '0; mark = 1'b0; ma = '0; clr = 1'b0;
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < int'(DEPTH); a++) begin
      ra1 = AW'(a);
      ra2 = AW'(DEPTH - 1 - a);
      cycle();
    end
  endtask

  task automatic fill(input logic mark6);
    for (int i = 0; i < int'(DEPTH); i++) begin
      we = 1'b1; wa = AW'(i); wd = W'(i + 1);
      mark = mark6 && (i == 7); ma = 3'd6;
      cycle();
    end
    set_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ra1 = '0; ra2 = '0;
    set_idle();
    m_reset();

    // Reset state: every address reads zero, not pending, not busy
    for (int a = 0; a < int'(DEPTH); a++) begin
      #2;
      ra1 = AW'(a); ra2 = AW'(DEPTH - 1 - a);
      #1;
      check_outputs();
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); m_edge(); #1;

    // Write with bypass (inst 0) versus without (inst 1)
    we = 1'b1; wa = 3'd5; wd = 32'hDEADBEEF; ra1 = 3'd5; ra2 = 3'd5;
    cycle();
    set_idle();
    cycle();

    // Mark, write clears pending, same-cycle mark+write leaves it set
    mark = 1'b1; ma = 3'd3; ra1 = 3'd3; ra2 = 3'd5;
    cycle();
    set_idle();
    cycle();
    we = 1'b1; wa = 3'd3; wd = 32'd7;
    cycle();
    set_idle();
    cycle();
    we = 1'b1; wa = 3'd3; wd = 32'h1234_5678; mark = 1'b1; ma = 3'd3;
    cycle();
    set_idle();
    cycle();

    // Zero register: write and mark to entry 0
    ra1 = 3'd0; ra2 = 3'd0;
    we = 1'b1; wa = 3'd0; wd = 32'hFFFFFFFF;
    cycle();
    set_idle();
    mark = 1'b1; ma = 3'd0;
    cycle();
    set_idle();
    cycle();

    // Full clear with writes/marks/clr attempted while busy
    fill(1'b1);
    ra1 = 3'd6; ra2 = 3'd7;
    clr = 1'b1;
    cycle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o[0]) break;
      n++;
      ra1 = AW'(n - 1); ra2 = AW'(n);
      we = 1'b1; wa = AW'($urandom); wd = $urandom;
      mark = 1'b1; ma = AW'($urandom); clr = 1'b1;
      cycle();
    end
    set_idle();
    chk("busy_len", W'(n), W'(DEPTH));
    sweep_reads();

    // Reset in the middle of a clear, then a clean clear afterwards
    fill(1'b1);
    clr = 1'b1;
    cycle();
    set_idle();
    for (int i = 0; i < 3; i++) cycle();
    #2 rst = 1'b1;
    #1 m_reset();
    check_outputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); m_edge(); #1;
    sweep_reads();
    fill(1'b0);
    clr = 1'b1;
    cycle();
    set_idle();
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      ra1 = AW'(i); ra2 = AW'(i + 1);
      cycle();
    end
    sweep_reads();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      ra1  = AW'($urandom);
      ra2  = AW'($urandom);
      we   = 1'($urandom_range(0, 1));
      wa   = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom);
      wd   = $urandom;
      mark = ($urandom_range(0, 3) == 0);
      ma   = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      clr  = ($urandom_range(0, 60) == 0);
      cycle();
    end
    set_idle();
    for (int i = 0; i < int'(DEPTH) + 1; i++) cycle();
    sweep_reads();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
